// File: rtl/serial_feeder_if.sv
// Load handshake and serial output bundle for serial_pattern_feeder.
// The producer/bench side uses the master modport and the feeder uses the slave modport.
interface serial_feeder_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             w;
  logic             w_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, w, w_valid, word_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, w, w_valid, word_done, busy
  );
endinterface

// File: rtl/serial_pattern_feeder.sv
// Parallel-to-serial feeder for the sequence detector's w input.
// Define SERIAL_FEEDER_PREBUF_EN to add a one-word hold register for gapless streaming.
module serial_pattern_feeder #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_feeder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             w_reg, w_next;
  logic             w_valid_reg, w_valid_next;
  logic             word_done_reg, word_done_next;

  logic             din_ready;
  logic             transfer;
  logic             last_bit;
  logic             load_din;
  logic             reload_hold;
  logic             hold_full;
  logic [WIDTH-1:0] hold_word;
  logic [WIDTH-1:0] load_word;

  function automatic logic head_bit(input logic [WIDTH-1:0] x);
    return MSB_FIRST ? x[WIDTH-1] : x[0];
  endfunction

  // Logical shift toward the output end; vacated bits take IDLE_LEVEL.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] x);
    return MSB_FIRST ? {x[WIDTH-2:0], IDLE_LEVEL} : {IDLE_LEVEL, x[WIDTH-1:1]};
  endfunction

  assign transfer    = bus.din_valid && din_ready;
  assign last_bit    = (state_reg == SHIFT) && (count_reg == '0);
  assign reload_hold = last_bit && hold_full;
  // A fresh word goes straight to the shifter when idle or when the shifter frees with nothing held.
  assign load_din    = transfer && ((state_reg == IDLE) || (last_bit && !hold_full));
  assign load_word   = reload_hold ? hold_word : bus.din;

`ifdef SERIAL_FEEDER_PREBUF_EN
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full_reg;

  assign din_ready = !hold_full_reg;
  assign hold_full = hold_full_reg;
  assign hold_word = hold_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
    end else begin
      if (reload_hold)
        hold_full_reg <= 1'b0;
      if (transfer && !load_din) begin
        hold_reg      <= bus.din;
        hold_full_reg <= 1'b1;
      end
    end
  end
`else
  assign din_ready = (state_reg == IDLE);
  assign hold_full = 1'b0;
  assign hold_word = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sr_reg        <= '0;
      count_reg     <= '0;
      w_reg         <= IDLE_LEVEL;
      w_valid_reg   <= 1'b0;
      word_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sr_reg        <= sr_next;
      count_reg     <= count_next;
      w_reg         <= w_next;
      w_valid_reg   <= w_valid_next;
      word_done_reg <= word_done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (transfer) state_next = SHIFT;
      SHIFT:   if (last_bit && !hold_full && !load_din) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // w/w_valid/word_done are computed one edge ahead so the outputs come straight from flops.
  always_comb begin
    sr_next        = sr_reg;
    count_next     = count_reg;
    w_next         = IDLE_LEVEL;
    w_valid_next   = 1'b0;
    word_done_next = 1'b0;
    if (load_din || reload_hold) begin
      w_next       = head_bit(load_word);
      sr_next      = advance(load_word);
      count_next   = CW'(WIDTH - 1);
      w_valid_next = 1'b1;
    end else if ((state_reg == SHIFT) && !last_bit) begin
      w_next         = head_bit(sr_reg);
      sr_next        = advance(sr_reg);
      count_next     = count_reg - 1'b1;
      w_valid_next   = 1'b1;
      word_done_next = (count_reg == CW'(1));
    end else begin
      sr_next    = {WIDTH{IDLE_LEVEL}};
      count_next = '0;
    end
  end

  assign bus.din_ready = din_ready;
  assign bus.w         = w_reg;
  assign bus.w_valid   = w_valid_reg;
  assign bus.word_done = word_done_reg;
  assign bus.busy      = (state_reg != IDLE) || hold_full;
endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Bench for serial_pattern_feeder: MSB-first and LSB-first instances driven in lockstep,
// checked against fixed vectors and a bit-queue reference model.
module tb_serial_pattern_feeder;
`ifdef SERIAL_FEEDER_PREBUF_EN
  localparam bit PREBUF = 1'b1;
`else
  localparam bit PREBUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  serial_feeder_if #(.WIDTH(8)) if_m ();
  serial_feeder_if #(.WIDTH(8)) if_l ();

  serial_pattern_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(if_m.slave));
  serial_pattern_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(if_l.slave));

  // Reference model: bits still to appear on w (head = bit currently shown) plus held words.
  logic       cur_m[$];
  logic       cur_l[$];
  logic [7:0] hold_q[$];

  typedef struct {
    logic       valid;
    logic [7:0] din;
    logic       wm;
    logic       wl;
    logic       wv;
    logic       done;
    logic       ready;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic model_ready();
    return PREBUF ? (hold_q.size() == 0) : (cur_m.size() == 0);
  endfunction

  task automatic model_clear();
    cur_m.delete();
    cur_l.delete();
    hold_q.delete();
  endtask

  task automatic model_load(input logic [7:0] word);
    for (int i = 0; i < 8; i++) begin
      cur_m.push_back(word[7-i]);
      cur_l.push_back(word[i]);
    end
  endtask

  // One rising edge of the reference behaviour, using the currently driven inputs.
  task automatic model_step(output logic xfer);
    logic placed;
    xfer   = if_m.din_valid && model_ready();
    placed = 1'b0;
    if (cur_m.size() > 0) begin
      void'(cur_m.pop_front());
      void'(cur_l.pop_front());
    end
    if (cur_m.size() == 0) begin
      if (hold_q.size() > 0) begin
        model_load(hold_q.pop_front());
      end else if (xfer) begin
        model_load(if_m.din);
        placed = 1'b1;
      end
    end
    if (xfer && !placed)
      hold_q.push_back(if_m.din);
  endtask

  task automatic model_check(input string tag);
    logic busy_e;
    busy_e = (cur_m.size() > 0) || (hold_q.size() > 0);
    chk({tag, ".w_m"},     if_m.w,         (cur_m.size() > 0) ? cur_m[0] : 1'b0);
    chk({tag, ".w_l"},     if_l.w,         (cur_l.size() > 0) ? cur_l[0] : 1'b0);
    chk({tag, ".wv_m"},    if_m.w_valid,   cur_m.size() > 0);
    chk({tag, ".wv_l"},    if_l.w_valid,   cur_l.size() > 0);
    chk({tag, ".done_m"},  if_m.word_done, cur_m.size() == 1);
    chk({tag, ".done_l"},  if_l.word_done, cur_l.size() == 1);
    chk({tag, ".ready_m"}, if_m.din_ready, model_ready());
    chk({tag, ".ready_l"}, if_l.din_ready, model_ready());
    chk({tag, ".busy_m"},  if_m.busy,      busy_e);
    chk({tag, ".busy_l"},  if_l.busy,      busy_e);
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    if_m.din_valid = v;
    if_l.din_valid = v;
    if_m.din       = d;
    if_l.din       = d;
  endtask

  task automatic do_cycle(input string tag, input logic v, input logic [7:0] d, output logic xfer);
    drive(v, d);
    @(negedge clk);
    model_check(tag);
    @(posedge clk);
    model_step(xfer);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       x;
    logic [7:0] cf_m, cf_l, h35_m, h35_l;
    logic [7:0] d;
    logic       v;
    int         sent;
    int         done_cyc[$];
    logic [15:0] stream;
    int         nbits;

    // Expected w sequences, first bit emitted at index 7.
    cf_m  = 8'b1100_1111;
    cf_l  = 8'b1111_0011;
    h35_m = 8'b0011_0101;
    h35_l = 8'b1010_1100;
    tbl[0] = '{valid: 1'b1, din: 8'hCF, wm: 1'b0, wl: 1'b0, wv: 1'b0, done: 1'b0, ready: 1'b1};
    for (int i = 0; i < 8; i++)
      tbl[1+i] = '{valid: 1'b0, din: 8'h00, wm: cf_m[7-i], wl: cf_l[7-i], wv: 1'b1,
                   done: (i == 7), ready: PREBUF};
    tbl[9] = '{valid: 1'b1, din: 8'h35, wm: 1'b0, wl: 1'b0, wv: 1'b0, done: 1'b0, ready: 1'b1};
    for (int i = 0; i < 8; i++)
      tbl[10+i] = '{valid: 1'b0, din: 8'h00, wm: h35_m[7-i], wl: h35_l[7-i], wv: 1'b1,
                    done: (i == 7), ready: PREBUF};
    tbl[18] = '{valid: 1'b0, din: 8'h00, wm: 1'b0, wl: 1'b0, wv: 1'b0, done: 1'b0, ready: 1'b1};

    drive(1'b0, 8'h00);
    apply_reset();

    // Idle after reset.
    for (int i = 0; i < 2; i++)
      do_cycle("idle", 1'b0, 8'h00, x);

    // Fixed single-word vectors: 8'hCF then 8'h35 on both bit orders.
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].valid, tbl[i].din);
      @(negedge clk);
      chk($sformatf("tbl%0d.w_m", i),   if_m.w,         tbl[i].wm);
      chk($sformatf("tbl%0d.w_l", i),   if_l.w,         tbl[i].wl);
      chk($sformatf("tbl%0d.wv", i),    if_m.w_valid,   tbl[i].wv);
      chk($sformatf("tbl%0d.done", i),  if_m.word_done, tbl[i].done);
      chk($sformatf("tbl%0d.ready", i), if_m.din_ready, tbl[i].ready);
      @(posedge clk);
      model_step(x);
      #1;
    end

    // din_valid held high across 8'hCF then 8'h5B.
    v = 1'b1;
    d = 8'hCF;
    sent = 0;
    stream = '0;
    nbits = 0;
    for (int c = 0; c < 24; c++) begin
      drive(v, d);
      @(negedge clk);
      model_check("b2b");
      if (if_m.word_done) done_cyc.push_back(c);
      if (if_m.w_valid && nbits < 16) begin
        stream = {stream[14:0], if_m.w};
        nbits++;
      end
      @(posedge clk);
      model_step(x);
      #1;
      if (x) begin
        sent++;
        if (sent == 1) d = 8'h5B;
        else v = 1'b0;
      end
    end
    chk_int("b2b.done_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2)
      chk_int("b2b.done_spacing", done_cyc[1] - done_cyc[0], PREBUF ? 8 : 9);
    chk_int("b2b.stream", int'(stream), 16'hCF5B);

    // Asynchronous reset during the 4th bit of 8'hCF.
    do_cycle("rst", 1'b1, 8'hCF, x);
    for (int i = 0; i < 3; i++)
      do_cycle("rst", 1'b0, 8'h00, x);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst.async_w",    if_m.w,         1'b0);
    chk("rst.async_wv",   if_m.w_valid,   1'b0);
    chk("rst.async_done", if_m.word_done, 1'b0);
    chk("rst.async_busy", if_l.busy,      1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_cycle("post_rst", 1'b0, 8'h00, x);
    do_cycle("post_rst", 1'b1, 8'hA5, x);
    for (int i = 0; i < 10; i++)
      do_cycle("post_rst", 1'b0, 8'h00, x);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++)
      do_cycle("rand", $urandom_range(0, 3) != 0, 8'($urandom), x);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
